// File: rtl/playback_pkg.sv
// playback_pkg: key codes, state/command types and divisor defaults for the playback sequencer.
// Rev 1.0
`default_nettype none

package playback_pkg;

  localparam logic [7:0] KEY_PLAY_UC    = 8'h45;
  localparam logic [7:0] KEY_PLAY_LC    = 8'h65;
  localparam logic [7:0] KEY_PAUSE_UC   = 8'h44;
  localparam logic [7:0] KEY_PAUSE_LC   = 8'h64;
  localparam logic [7:0] KEY_FWD_UC     = 8'h46;
  localparam logic [7:0] KEY_FWD_LC     = 8'h66;
  localparam logic [7:0] KEY_BWD_UC     = 8'h42;
  localparam logic [7:0] KEY_BWD_LC     = 8'h62;
  localparam logic [7:0] KEY_RESTART_UC = 8'h52;
  localparam logic [7:0] KEY_RESTART_LC = 8'h72;

  localparam int unsigned PB_DIV_DEFAULT  = 1227;
  localparam int unsigned PB_DIV_STEP     = 16;
  localparam int unsigned PB_DIV_MIN      = 256;
  localparam int unsigned PB_DIV_MAX      = 8192;
  localparam int unsigned PB_RESTART_HOLD = 4;

  typedef enum logic [1:0] {PAUSED, PLAYING, RESTARTING} pb_state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PLAY,
    CMD_PAUSE,
    CMD_FWD,
    CMD_BWD,
    CMD_RESTART
  } key_cmd_t;

  function automatic key_cmd_t decode_key(input logic [7:0] code);
    key_cmd_t cmd;
    case (code)
      KEY_PLAY_UC,    KEY_PLAY_LC:    cmd = CMD_PLAY;
      KEY_PAUSE_UC,   KEY_PAUSE_LC:   cmd = CMD_PAUSE;
      KEY_FWD_UC,     KEY_FWD_LC:     cmd = CMD_FWD;
      KEY_BWD_UC,     KEY_BWD_LC:     cmd = CMD_BWD;
      KEY_RESTART_UC, KEY_RESTART_LC: cmd = CMD_RESTART;
      default:                        cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_pulse_sync.sv
// edge_pulse_sync: 2-FF synchroniser followed by a registered rising-edge detector.
// Rev 1.0
`default_nettype none

module edge_pulse_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/playback_controller.sv
// playback_controller: turns keyboard commands and speed buttons into registered fetcher controls.
// Rev 1.0
`default_nettype none

module playback_controller
  import playback_pkg::*;
#(
  parameter int unsigned DIV_DEFAULT  = PB_DIV_DEFAULT,
  parameter int unsigned DIV_STEP     = PB_DIV_STEP,
  parameter int unsigned DIV_MIN      = PB_DIV_MIN,
  parameter int unsigned DIV_MAX      = PB_DIV_MAX,
  parameter int unsigned RESTART_HOLD = PB_RESTART_HOLD
) (
  input  logic        clk_27,
  input  logic        rst,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  input  logic        speed_up,
  input  logic        speed_down,
  input  logic        speed_reset,
  output logic        paused,
  output logic        forward,
  output logic [31:0] sample_freq_div,
  output logic        restart_out
);

  localparam int unsigned CNT_W = (RESTART_HOLD > 1) ? $clog2(RESTART_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RESTART_HOLD - 1);

  localparam logic [31:0] DIV_DEFAULT_W = 32'(DIV_DEFAULT);
  localparam logic [31:0] DIV_STEP_W    = 32'(DIV_STEP);
  localparam logic [31:0] DIV_MIN_W     = 32'(DIV_MIN);
  localparam logic [31:0] DIV_MAX_W     = 32'(DIV_MAX);

  key_cmd_t          cmd;
  pb_state_t         state, state_next;
  logic              resume_play, resume_play_next;
  logic [CNT_W-1:0]  hold_cnt, hold_cnt_next;
  logic              up_pulse, down_pulse, reset_pulse;
  logic [31:0]       div_next;

  assign cmd = key_valid ? decode_key(key_code) : CMD_NONE;

  edge_pulse_sync u_sync_up (
    .clk      (clk_27),
    .rst      (rst),
    .async_in (speed_up),
    .pulse    (up_pulse)
  );

  edge_pulse_sync u_sync_down (
    .clk      (clk_27),
    .rst      (rst),
    .async_in (speed_down),
    .pulse    (down_pulse)
  );

  edge_pulse_sync u_sync_reset (
    .clk      (clk_27),
    .rst      (rst),
    .async_in (speed_reset),
    .pulse    (reset_pulse)
  );

  // Hold expiry looks at the updated resume so a PLAY/PAUSE on the last hold cycle still counts.
  always_comb begin
    state_next       = state;
    resume_play_next = resume_play;
    hold_cnt_next    = hold_cnt;
    case (state)
      PAUSED: begin
        if (cmd == CMD_PLAY) begin
          state_next = PLAYING;
        end else if (cmd == CMD_RESTART) begin
          state_next       = RESTARTING;
          resume_play_next = 1'b0;
          hold_cnt_next    = HOLD_LOAD;
        end
      end
      PLAYING: begin
        if (cmd == CMD_PAUSE) begin
          state_next = PAUSED;
        end else if (cmd == CMD_RESTART) begin
          state_next       = RESTARTING;
          resume_play_next = 1'b1;
          hold_cnt_next    = HOLD_LOAD;
        end
      end
      RESTARTING: begin
        if (cmd == CMD_RESTART) begin
          hold_cnt_next = HOLD_LOAD;
        end else begin
          if (cmd == CMD_PLAY) begin
            resume_play_next = 1'b1;
          end else if (cmd == CMD_PAUSE) begin
            resume_play_next = 1'b0;
          end
          if (hold_cnt == '0) begin
            state_next = resume_play_next ? PLAYING : PAUSED;
          end else begin
            hold_cnt_next = hold_cnt - 1'b1;
          end
        end
      end
      default: state_next = PAUSED;
    endcase
  end

  always_ff @(posedge clk_27) begin
    if (rst) begin
      state       <= PAUSED;
      resume_play <= 1'b0;
      hold_cnt    <= '0;
      paused      <= 1'b1;
      restart_out <= 1'b0;
    end else begin
      state       <= state_next;
      resume_play <= resume_play_next;
      hold_cnt    <= hold_cnt_next;
      paused      <= (state_next != PLAYING);
      restart_out <= (state_next == RESTARTING);
    end
  end

  always_ff @(posedge clk_27) begin
    if (rst) begin
      forward <= 1'b1;
    end else if (cmd == CMD_FWD) begin
      forward <= 1'b1;
    end else if (cmd == CMD_BWD) begin
      forward <= 1'b0;
    end
  end

  // Bounds are tested before the add/subtract so the result cannot wrap.
  always_comb begin
    div_next = sample_freq_div;
    if (reset_pulse) begin
      div_next = DIV_DEFAULT_W;
    end else if (up_pulse && !down_pulse) begin
      div_next = (sample_freq_div >= DIV_MIN_W + DIV_STEP_W) ?
                 sample_freq_div - DIV_STEP_W : DIV_MIN_W;
    end else if (down_pulse && !up_pulse) begin
      div_next = (sample_freq_div >= DIV_MAX_W - DIV_STEP_W) ?
                 DIV_MAX_W : sample_freq_div + DIV_STEP_W;
    end
  end

  always_ff @(posedge clk_27) begin
    if (rst) begin
      sample_freq_div <= DIV_DEFAULT_W;
    end else begin
      sample_freq_div <= div_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_playback_controller.sv
// tb_playback_controller: directed stimulus, cycle-by-cycle check against a behavioural model.
// Rev 1.0
`default_nettype none

module tb_playback_controller;

  logic        clk_27 = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  key_code = 8'h00;
  logic        key_valid = 1'b0;
  logic        speed_up = 1'b0;
  logic        speed_down = 1'b0;
  logic        speed_reset = 1'b0;
  logic        paused;
  logic        forward;
  logic [31:0] sample_freq_div;
  logic        restart_out;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_27 = ~clk_27;

  playback_controller dut (
    .clk_27          (clk_27),
    .rst             (rst),
    .key_code        (key_code),
    .key_valid       (key_valid),
    .speed_up        (speed_up),
    .speed_down      (speed_down),
    .speed_reset     (speed_reset),
    .paused          (paused),
    .forward         (forward),
    .sample_freq_div (sample_freq_div),
    .restart_out     (restart_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: play intent, remaining restart cycles, and raw button sample history.
  bit         m_valid = 1'b0;
  bit         m_play;
  bit         m_fwd;
  int         m_hold;
  int         m_div;
  bit [3:0]   hu, hd, hr;
  bit         pu, pd, pr, m_restart_key;
  logic [7:0] k;

  always @(posedge clk_27) begin
    if (rst) begin
      m_play = 1'b0;
      m_fwd  = 1'b1;
      m_hold = 0;
      m_div  = 1227;
      hu = '0; hd = '0; hr = '0;
    end else begin
      // A press changes the divisor on the 4th edge after the level first rises.
      pu = hu[2] && !hu[3];
      pd = hd[2] && !hd[3];
      pr = hr[2] && !hr[3];
      m_restart_key = 1'b0;
      if (key_valid) begin
        k = key_code;
        if (k >= 8'h61 && k <= 8'h7a) k = k - 8'h20;
        case (k)
          8'h45: m_play = 1'b1;
          8'h44: m_play = 1'b0;
          8'h46: m_fwd = 1'b1;
          8'h42: m_fwd = 1'b0;
          8'h52: m_restart_key = 1'b1;
          default: ;
        endcase
      end
      if (m_restart_key) m_hold = 4;
      else if (m_hold > 0) m_hold = m_hold - 1;
      if (pr) m_div = 1227;
      else if (pu && !pd) m_div = (m_div - 16 < 256) ? 256 : m_div - 16;
      else if (pd && !pu) m_div = (m_div + 16 > 8192) ? 8192 : m_div + 16;
      hu = {hu[2:0], speed_up};
      hd = {hd[2:0], speed_down};
      hr = {hr[2:0], speed_reset};
    end
    m_valid = 1'b1;
  end

  always @(negedge clk_27) begin
    if (m_valid) begin
      check("model_paused",  {31'd0, paused},      {31'd0, (m_hold > 0) || !m_play});
      check("model_restart", {31'd0, restart_out}, {31'd0, m_hold > 0});
      check("model_forward", {31'd0, forward},     {31'd0, m_fwd});
      check("model_div",     sample_freq_div,      m_div);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_27);
  endtask

  task automatic send_key(input logic [7:0] c, input logic v);
    key_code  = c;
    key_valid = v;
    @(negedge clk_27);
    key_valid = 1'b0;
  endtask

  task automatic press(input logic u, input logic d, input logic r);
    speed_up = u; speed_down = d; speed_reset = r;
    tick(4);
    speed_up = 1'b0; speed_down = 1'b0; speed_reset = 1'b0;
    tick(4);
  endtask

  task automatic count_restart(output int cnt);
    cnt = 0;
    repeat (8) begin
      if (restart_out === 1'b1) begin
        cnt++;
        check("paused_in_hold", {31'd0, paused}, 32'd1);
      end
      @(negedge clk_27);
    end
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    int          c;
    int          changes;
    int          first;
    logic [31:0] prev_div;

    tick(3);
    check("rst_paused",  {31'd0, paused},      32'd1);
    check("rst_forward", {31'd0, forward},     32'd1);
    check("rst_div",     sample_freq_div,      32'd1227);
    check("rst_restart", {31'd0, restart_out}, 32'd0);
    rst = 1'b0;
    tick(1);

    send_key(8'h45, 1'b1);
    check("play_paused",  {31'd0, paused},  32'd0);
    check("play_forward", {31'd0, forward}, 32'd1);
    check("play_div",     sample_freq_div,  32'd1227);
    send_key(8'h44, 1'b1);
    check("pause_paused", {31'd0, paused},  32'd1);

    send_key(8'h65, 1'b1);
    send_key(8'h42, 1'b1);
    check("bwd_forward", {31'd0, forward}, 32'd0);
    check("bwd_paused",  {31'd0, paused},  32'd0);
    send_key(8'h66, 1'b1);
    check("fwd_forward", {31'd0, forward}, 32'd1);

    send_key(8'h52, 1'b1);
    count_restart(c);
    check("restart_len_playing", c, 32'd4);
    check("resume_playing", {31'd0, paused}, 32'd0);

    send_key(8'h64, 1'b1);
    send_key(8'h72, 1'b1);
    count_restart(c);
    check("restart_len_paused", c, 32'd4);
    check("resume_paused", {31'd0, paused}, 32'd1);

    send_key(8'h52, 1'b1);
    tick(1);
    send_key(8'h52, 1'b1);
    count_restart(c);
    check("restart_extend", c, 32'd4);

    send_key(8'h52, 1'b1);
    send_key(8'h45, 1'b1);
    tick(6);
    check("resume_updated_in_hold", {31'd0, paused}, 32'd0);
    check("hold_done", {31'd0, restart_out}, 32'd0);

    speed_up = 1'b1;
    changes = 0;
    first = -1;
    prev_div = sample_freq_div;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk_27);
      if (sample_freq_div !== prev_div) begin
        changes++;
        if (first < 0) first = i;
        prev_div = sample_freq_div;
      end
    end
    check("held_up_changes", changes, 32'd1);
    check("held_up_latency", first, 32'd4);
    check("held_up_div", sample_freq_div, 32'd1211);
    speed_up = 1'b0;
    tick(4);

    repeat (70) press(1'b1, 1'b0, 1'b0);
    check("div_sat_min", sample_freq_div, 32'd256);
    press(1'b0, 1'b0, 1'b1);
    check("speed_reset", sample_freq_div, 32'd1227);
    press(1'b1, 1'b1, 1'b0);
    check("up_down_same", sample_freq_div, 32'd1227);
    press(1'b1, 1'b0, 1'b0);
    check("one_up", sample_freq_div, 32'd1211);
    press(1'b0, 1'b1, 1'b1);
    check("reset_priority", sample_freq_div, 32'd1227);
    repeat (436) press(1'b0, 1'b1, 1'b0);
    check("div_reach_max", sample_freq_div, 32'd8192);
    press(1'b0, 1'b1, 1'b0);
    check("div_sat_max", sample_freq_div, 32'd8192);

    send_key(8'h44, 1'b1);
    send_key(8'h46, 1'b1);
    send_key(8'h41, 1'b1);
    check("ignore_a_paused",  {31'd0, paused},      32'd1);
    check("ignore_a_forward", {31'd0, forward},     32'd1);
    check("ignore_a_restart", {31'd0, restart_out}, 32'd0);
    check("ignore_a_div",     sample_freq_div,      32'd8192);
    send_key(8'h45, 1'b0);
    tick(1);
    check("ignore_invalid_paused", {31'd0, paused}, 32'd1);

    send_key(8'h42, 1'b1);
    send_key(8'h52, 1'b1);
    tick(1);
    check("pre_rst_restart", {31'd0, restart_out}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_restart", {31'd0, restart_out}, 32'd0);
    check("mid_rst_paused",  {31'd0, paused},      32'd1);
    check("mid_rst_forward", {31'd0, forward},     32'd1);
    check("mid_rst_div",     sample_freq_div,      32'd1227);
    rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
